// File: rtl/and_bist.sv
// Exhaustive built-in self test for a combinational WIDTH-bit AND gate.
// Sweeps every (a, b) operand pair, counts mismatches and records the first failing pair.
module and_bist #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dut_out,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a single-cycle request with no ready. It is acted on
  // only when the engine is idle (IDLE or DONE); while busy it is dropped.
  // done/pass are levels that hold until the next accepted start or rst.

  localparam int VW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [VW-1:0]   vec;
  logic            last_vec;
  logic            mismatch;

  assign last_vec = (vec == {VW{1'b1}});
  assign mismatch = (dut_out != (op_a & op_b));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = APPLY;
      APPLY:   state_nxt = CHECK;
      CHECK:   state_nxt = last_vec ? DONE : APPLY;
      DONE:    if (start) state_nxt = APPLY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec       <= '0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
          end
        end
        APPLY: begin
          op_a <= vec[VW-1:WIDTH];
          op_b <= vec[WIDTH-1:0];
        end
        CHECK: begin
          // The count saturates, so it can never return to zero within a sweep
          // and the first captured pair is never overwritten.
          if (mismatch) begin
            if (err_count == 8'd0) begin
              fail_a <= op_a;
              fail_b <= op_b;
            end
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end
          if (!last_vec) begin
            vec <= vec + {{(VW-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == APPLY) || (state == CHECK);
  assign done      = (state == DONE);
  assign pass      = (state == DONE) && (err_count == 8'd0);
  assign state_dbg = state;

endmodule

// File: tb/tb_and_bist.sv
// Self-checking bench for and_bist: a time-indexed sweep model checks every cycle,
// plus literal end-of-sweep results for the classic fault models.
module tb_and_bist;

  localparam int W = 4;
  localparam int N = 1 << (2 * W);
  localparam int SWEEP = 2 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dut_out;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic         pass;
  logic [7:0]   err_count;
  logic [W-1:0] fail_a;
  logic [W-1:0] fail_b;
  logic [1:0]   state_dbg;

  int           mode;
  logic [W-1:0] flip [N];
  bit           mm [N];
  int           pre_err [N+1];
  int           pre_ff [N+1];
  int           t;
  int           checks;
  int           failures;

  always #5 clk = ~clk;

  and_bist #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_a(fail_a), .fail_b(fail_b), .state_dbg(state_dbg)
  );

  // Gate under test: 0 good AND, 1 stuck-0, 2 OR, 3 stuck-1, 4 AND with random flips
  function automatic logic [W-1:0] gate(int m, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] fl);
    case (m)
      0:       return a & b;
      1:       return '0;
      2:       return a | b;
      3:       return '1;
      default: return (a & b) ^ fl;
    endcase
  endfunction

  assign dut_out = gate(mode, op_a, op_b, flip[{op_a, op_b}]);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", name, t, act, exp);
    end
  endtask

  task automatic set_mode(int m);
    logic [W-1:0] a;
    logic [W-1:0] b;
    mode = m;
    for (int k = 0; k < N; k++) begin
      flip[k] = '0;
      if (m == 4 && $urandom_range(0, 5) == 0) flip[k] = W'($urandom_range(1, (1 << W) - 1));
      a = W'(k >> W);
      b = W'(k);
      mm[k] = (gate(m, a, b, flip[k]) != (a & b));
    end
  endtask

  // Sweep model indexed by edges since the accepted start: vector k is applied on
  // edge 2k+1 and judged on edge 2k+2; after edge 2N the sweep is complete.
  always begin
    int n;
    int k;
    int e;
    bit bz;
    bit dn;
    @(posedge clk);
    if (rst) begin
      t = -1;
    end else if ((t == -1 || t >= SWEEP) && start) begin
      t = 0;
      pre_err[0] = 0;
      pre_ff[0] = -1;
      for (int i = 0; i < N; i++) begin
        pre_err[i+1] = pre_err[i] + (mm[i] ? 1 : 0);
        pre_ff[i+1]  = (pre_ff[i] < 0 && mm[i]) ? i : pre_ff[i];
      end
    end else if (t >= 0 && t < SWEEP) begin
      t = t + 1;
    end
    @(negedge clk);
    if (t != -2) begin
      n  = (t > 0) ? t / 2 : 0;
      e  = (pre_err[n] > 255) ? 255 : pre_err[n];
      bz = (t >= 0 && t < SWEEP);
      dn = (t >= SWEEP);
      if (t < 0) begin
        e = 0;
        n = 0;
      end
      check("busy", 32'(bz), 32'(busy));
      check("done", 32'(done), 32'(dn));
      check("pass", 32'(pass), 32'(dn && e == 0));
      check("err_count", 32'(err_count), 32'(e));
      if (t < 0 || pre_ff[n] < 0) begin
        check("fail_a", 32'(fail_a), 0);
        check("fail_b", 32'(fail_b), 0);
      end else begin
        check("fail_a", 32'(fail_a), 32'(pre_ff[n] >> W));
        check("fail_b", 32'(fail_b), 32'(pre_ff[n] % (1 << W)));
      end
      if (t == -1) begin
        check("op_a_rst", 32'(op_a), 0);
        check("op_b_rst", 32'(op_b), 0);
      end else if (t >= 1) begin
        k = (t - 1) / 2;
        if (k > N - 1) k = N - 1;
        check("op_a", 32'(op_a), 32'(k >> W));
        check("op_b", 32'(op_b), 32'(k % (1 << W)));
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs one sweep; repulse_at >= 0 re-asserts start that many edges into the sweep.
  task automatic run_sweep(int m, int repulse_at, bit lits, int e_err, int e_fa, int e_fb);
    int cyc;
    set_mode(m);
    pulse_start();
    cyc = 0;
    while (!done && cyc < SWEEP + 50) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == repulse_at) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check("sweep_cycles", 32'(cyc + 1), 32'(SWEEP + 1));
    if (lits) begin
      check("final_done", 32'(done), 1);
      check("final_err", 32'(err_count), 32'(e_err));
      check("final_pass", 32'(pass), 32'(e_err == 0));
      check("final_fail_a", 32'(fail_a), 32'(e_fa));
      check("final_fail_b", 32'(fail_b), 32'(e_fb));
    end
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  initial begin
    t = -2;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    set_mode(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_err", 32'(err_count), 0);
    repeat (4) @(posedge clk);

    run_sweep(0, -1, 1'b1, 0, 0, 0);
    run_sweep(1, -1, 1'b1, 175, 1, 1);
    run_sweep(2, -1, 1'b1, 240, 0, 1);
    run_sweep(3, -1, 1'b1, 255, 0, 0);
    run_sweep(1, 50, 1'b1, 175, 1, 1);

    // reset mid-sweep, then a clean sweep
    set_mode(0);
    pulse_start();
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_op_a", 32'(op_a), 0);
    run_sweep(0, -1, 1'b1, 0, 0, 0);

    // rst and start together: rst wins
    @(posedge clk);
    #1 begin rst = 1'b1; start = 1'b1; end
    @(posedge clk);
    #1 begin rst = 1'b0; start = 1'b0; end
    @(negedge clk);
    check("rst_over_start_busy", 32'(busy), 0);
    check("rst_over_start_done", 32'(done), 0);

    for (int i = 0; i < 4; i++) begin
      run_sweep(4, $urandom_range(1, SWEEP - 2), 1'b0, 0, 0, 0);
    end
    run_sweep(int'($urandom_range(0, 4)), -1, 1'b0, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
